// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Purpose:
//   A memory-side responder for the core's data-memory port. It turns a plain
//   address / write-data / write-enable request into a valid/ready request and
//   response transaction. Each transaction has a fixed number of wait states.
//   The responder is backed by an internal word-addressed RAM.
//   It gives a multi-cycle, stalling core a realistic slow memory to stall
//   against. Only one request can be outstanding at a time.
//
// Parameters:
//   DEPTH    number of 32-bit words in the RAM. Word index = req_addr[31:2].
//   LATENCY  wait cycles between request accept and response valid (0..15).
//
// Ports:
//   clk        in   1   rising-edge clock
//   arst       in   1   asynchronous reset, active low
//   req_valid  in   1   initiator presents a request
//   req_ready  out  1   responder accepts a request this cycle
//   req_addr   in   32  byte address, must be word aligned
//   req_wdata  in   32  store data (ignored for loads)
//   req_we     in   1   1 = store, 0 = load
//   rsp_valid  out  1   response available
//   rsp_ready  in   1   initiator takes the response
//   rsp_rdata  out  32  load data; 0 for stores and errors
//   rsp_err    out  1   request was misaligned or out of range
//
// Timing:
//   A request accepted at edge N has rsp_valid high after edge N+LATENCY+1.
//   Back-to-back requests are spaced at least LATENCY+3 cycles apart.
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT_W   = 4'(LATENCY);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Goes high on the first clock edge after reset is released. While reset
  // is held it keeps req_ready low, even though the state is IDLE.
  logic        ready_q;

  // Request captured at the accept edge. The live request inputs are not
  // looked at again until the next accept.
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;

  logic        rsp_err_q;
  logic [31:0] rd_data_q;

  logic          accept;
  logic          commit;
  logic          rsp_done;
  logic          req_err;
  logic [AW-1:0] idx;

  logic [31:0] ram [DEPTH];

  // The address is checked from the captured request. The error decision is
  // therefore ready before the RAM is touched at the commit edge.
  assign idx     = addr_q[AW+1:2];
  assign req_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DEPTH_W);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  // The wait phase lasts LATENCY+1 cycles: the counter is loaded with LATENCY
  // and the commit happens on the edge where it is already zero. This puts
  // the RAM access (and rsp_valid) exactly at accept + LATENCY + 1. It also
  // works for LATENCY = 0 without a special path that would read the RAM
  // straight from the live request inputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    rsp_done  = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = ready_q;
        if (req_valid && ready_q) begin
          accept  = 1'b1;
          cnt_d   = LAT_W;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        // req_ready stays low here, even during the handshake. A request
        // shown in the same cycle is therefore taken in the following
        // IDLE cycle.
        if (rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read data is shown only for a good load while the response is pending.
  // The reset-free RAM output register never leaks out, and reset clears the
  // output at once through state_q.
  always_comb begin
    rsp_rdata = 32'd0;
    if ((state_q == S_RESP) && !rsp_err_q && !we_q) begin
      rsp_rdata = rd_data_q;
    end
  end

  assign rsp_err = rsp_err_q;

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      we_q    <= req_we;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      rsp_err_q <= 1'b0;
    end else if (commit) begin
      rsp_err_q <= req_err;
    end else if (rsp_done) begin
      rsp_err_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM with registered read port (no reset, so it maps onto block RAM)
  // ---------------------------------------------------------------------------
  // Reset forces state_q back to IDLE, so commit cannot fire once reset is
  // asserted. A store aborted in WAIT is therefore never written.
  always_ff @(posedge clk) begin
    if (commit && we_q && !req_err) begin
      ram[idx] <= wdata_q;
    end
    if (commit) begin
      rd_data_q <= ram[idx];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. It uses two instances:
//   u_dut0: DEPTH=256, LATENCY=2 (most scenarios)
//   u_dut1: DEPTH=256, LATENCY=0 (back-to-back traffic)
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_rdata [2];

  int n_chk = 0;
  int n_bad = 0;

  dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut0 (
    .clk       (clk),
    .arst      (arst),
    .req_valid (req_valid[0]),
    .req_ready (req_ready[0]),
    .req_addr  (req_addr[0]),
    .req_wdata (req_wdata[0]),
    .req_we    (req_we[0]),
    .rsp_valid (rsp_valid[0]),
    .rsp_ready (rsp_ready[0]),
    .rsp_rdata (rsp_rdata[0]),
    .rsp_err   (rsp_err[0])
  );

  dmem_responder #(.DEPTH(256), .LATENCY(0)) u_dut1 (
    .clk       (clk),
    .arst      (arst),
    .req_valid (req_valid[1]),
    .req_ready (req_ready[1]),
    .req_addr  (req_addr[1]),
    .req_wdata (req_wdata[1]),
    .req_we    (req_we[1]),
    .rsp_valid (rsp_valid[1]),
    .rsp_ready (rsp_ready[1]),
    .rsp_rdata (rsp_rdata[1]),
    .rsp_err   (rsp_err[1])
  );

  // Back-to-back vectors for the zero-latency instance
  logic [31:0] b_addr [4] = '{32'h0, 32'h4, 32'h0, 32'h4};
  logic [31:0] b_wd   [4] = '{32'h11, 32'h22, 32'h0, 32'h0};
  logic        b_we   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] b_exp  [4] = '{32'h0, 32'h0, 32'h11, 32'h22};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, wait for it to be accepted, then scramble the
  // inputs to show they are only sampled at the accept edge.
  task automatic send(input int d, input logic we, input logic [31:0] a, input logic [31:0] w);
    int n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("send_ready", {31'd0, req_ready[d]}, 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = a;
    req_wdata[d] = w;
    tick();
    req_valid[d] = 1'b0;
    req_we[d]    = ~we;
    req_addr[d]  = 32'h3C;
    req_wdata[d] = 32'hFFFF_FFFF;
  endtask

  // Count the cycles from the accept edge until rsp_valid is seen.
  task automatic wait_rsp(input int d, input int lat, input string tag);
    int n = 0;
    while (rsp_valid[d] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat + 1));
  endtask

  // Handshake, then check that the response outputs clear on the next cycle.
  task automatic take(input int d, input string tag);
    rsp_ready[d] = 1'b1;
    tick();
    rsp_ready[d] = 1'b0;
    chk({tag, "_clr_v"}, {31'd0, rsp_valid[d]}, 32'd0);
    chk({tag, "_clr_d"}, rsp_rdata[d], 32'd0);
    chk({tag, "_clr_e"}, {31'd0, rsp_err[d]}, 32'd0);
  endtask

  task automatic xfer(input int d, input logic we, input logic [31:0] a, input logic [31:0] w,
                      input int lat, input logic [31:0] exp_d, input logic exp_e, input string tag);
    send(d, we, a, w);
    wait_rsp(d, lat, tag);
    $display("txn %s: we=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0d",
             tag, we, a, w, rsp_rdata[d], rsp_err[d]);
    chk({tag, "_data"}, rsp_rdata[d], exp_d);
    chk({tag, "_err"}, {31'd0, rsp_err[d]}, {31'd0, exp_e});
    take(d, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int ai, ri, last_acc, n;
    logic rdy_prev;

    arst      = 1'b0;
    req_valid = '0;
    req_we    = '0;
    rsp_ready = '0;
    for (int i = 0; i < 2; i++) begin
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
    end

    // Reset state while reset is held across clock edges
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", {31'd0, req_ready[0]}, 32'd0);
    chk("rst_ready1", {31'd0, req_ready[1]}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid[0]}, 32'd0);
    chk("rst_rdata", rsp_rdata[0], 32'd0);
    chk("rst_err", {31'd0, rsp_err[0]}, 32'd0);
    #3 arst = 1'b1;
    #2;
    chk("rel_ready_pre", {31'd0, req_ready[0]}, 32'd0);
    tick();
    chk("rel_ready_post", {31'd0, req_ready[0]}, 32'd1);

    // 1: store then load, LATENCY=2
    xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, "st10");
    xfer(0, 1'b0, 32'h10, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, "ld10");

    // 2: error cases leave the RAM untouched
    xfer(0, 1'b0, 32'h12, 32'h0, 2, 32'h0, 1'b1, "ld12_mis");
    xfer(0, 1'b1, 32'h0, 32'h1234_5678, 2, 32'h0, 1'b0, "st00");
    xfer(0, 1'b1, 32'h400, 32'h1, 2, 32'h0, 1'b1, "st400_oor");
    xfer(0, 1'b0, 32'h0, 32'h0, 2, 32'h1234_5678, 1'b0, "ld00");
    xfer(0, 1'b1, 32'h11, 32'h99, 2, 32'h0, 1'b1, "st11_mis");
    xfer(0, 1'b0, 32'h10, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, "ld10b");

    // 3: response held for 5 cycles with rsp_ready low
    send(0, 1'b0, 32'h10, 32'h0);
    wait_rsp(0, 2, "hold");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", {31'd0, rsp_valid[0]}, 32'd1);
      chk("hold_data", rsp_rdata[0], 32'hDEAD_BEEF);
      chk("hold_ready", {31'd0, req_ready[0]}, 32'd0);
    end
    $display("txn hold: load 0x10 held 5 cycles rdata=0x%08h", rsp_rdata[0]);
    take(0, "hold");

    // 4: request held valid during the response handshake cycle
    send(0, 1'b1, 32'h24, 32'hCAFE_F00D);
    wait_rsp(0, 2, "st24");
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 32'h24;
    tick();
    rsp_ready[0] = 1'b0;
    chk("ovl_valid", {31'd0, rsp_valid[0]}, 32'd0);
    chk("ovl_not_acc", {31'd0, req_ready[0]}, 32'd1);
    tick();
    req_valid[0] = 1'b0;
    chk("ovl_acc", {31'd0, req_ready[0]}, 32'd0);
    wait_rsp(0, 2, "ovl");
    chk("ovl_data", rsp_rdata[0], 32'hCAFE_F00D);
    $display("txn ovl: load 0x24 rdata=0x%08h", rsp_rdata[0]);
    take(0, "ovl");

    // 5: LATENCY=0, back-to-back with rsp_ready tied high
    rsp_ready[1] = 1'b1;
    ai = 0; ri = 0; last_acc = -1; n = 0;
    req_valid[1] = 1'b1;
    req_we[1]    = b_we[0];
    req_addr[1]  = b_addr[0];
    req_wdata[1] = b_wd[0];
    rdy_prev     = req_ready[1];
    while ((ai < 4 || ri < 4) && n < 60) begin
      tick();
      n++;
      if (rsp_valid[1] === 1'b1 && ri < 4) begin
        chk("b2b_lat", 32'(n - last_acc), 32'd1);
        chk("b2b_data", rsp_rdata[1], b_exp[ri]);
        $display("txn b2b%0d: rdata=0x%08h err=%0d", ri, rsp_rdata[1], rsp_err[1]);
        ri++;
      end
      if (rdy_prev === 1'b1 && req_valid[1] === 1'b1) begin
        if (last_acc >= 0) chk("b2b_gap", 32'(n - last_acc), 32'd3);
        last_acc = n;
        ai++;
        if (ai < 4) begin
          req_we[1]    = b_we[ai];
          req_addr[1]  = b_addr[ai];
          req_wdata[1] = b_wd[ai];
        end else begin
          req_valid[1] = 1'b0;
        end
      end
      rdy_prev = req_ready[1];
    end
    chk("b2b_rsp_count", 32'(ri), 32'd4);
    chk("b2b_acc_count", 32'(ai), 32'd4);
    rsp_ready[1] = 1'b0;

    // 6: reset in WAIT aborts a pending store
    xfer(0, 1'b1, 32'h20, 32'hA5A5_A5A5, 2, 32'h0, 1'b0, "st20");
    send(0, 1'b1, 32'h20, 32'h55);
    tick();
    arst = 1'b0;
    #1;
    chk("arst_wait_ready", {31'd0, req_ready[0]}, 32'd0);
    chk("arst_wait_valid", {31'd0, rsp_valid[0]}, 32'd0);
    @(posedge clk);
    #2 arst = 1'b1;
    tick();
    chk("arst_wait_rel", {31'd0, req_ready[0]}, 32'd1);
    $display("txn st20_abort: store 0x55 dropped by reset");

    // Reset in RESP drops the response at once
    send(0, 1'b0, 32'h10, 32'h0);
    wait_rsp(0, 2, "rsp_rst");
    chk("rsp_rst_pre", rsp_rdata[0], 32'hDEAD_BEEF);
    arst = 1'b0;
    #1;
    chk("rsp_rst_valid", {31'd0, rsp_valid[0]}, 32'd0);
    chk("rsp_rst_data", rsp_rdata[0], 32'd0);
    @(posedge clk);
    #2 arst = 1'b1;
    tick();
    $display("txn rsp_rst: response dropped by reset");

    xfer(0, 1'b0, 32'h20, 32'h0, 2, 32'hA5A5_A5A5, 1'b0, "ld20");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
